// File: rtl/n1_sarb_ctrl.sv
// Stack bus arbiter: shares the N1 stack bus between the parameter stack (PS)
// and return stack (RS) initiators, one whole bus cycle at a time, round-robin on ties.
module n1_sarb_ctrl #(
  parameter int unsigned SP_WIDTH = 12
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  // PS initiator
  input  logic                ps_cyc_i,
  input  logic                ps_stb_i,
  input  logic                ps_we_i,
  input  logic [SP_WIDTH-1:0] ps_adr_i,
  input  logic [15:0]         ps_dat_i,
  output logic                ps_ack_o,
  output logic                ps_err_o,
  output logic                ps_rty_o,
  output logic                ps_stall_o,
  output logic [15:0]         ps_dat_o,
  // RS initiator
  input  logic                rs_cyc_i,
  input  logic                rs_stb_i,
  input  logic                rs_we_i,
  input  logic [SP_WIDTH-1:0] rs_adr_i,
  input  logic [15:0]         rs_dat_i,
  output logic                rs_ack_o,
  output logic                rs_err_o,
  output logic                rs_rty_o,
  output logic                rs_stall_o,
  output logic [15:0]         rs_dat_o,
  // Stack bus
  output logic                sbus_cyc_o,
  output logic                sbus_stb_o,
  output logic                sbus_we_o,
  output logic [SP_WIDTH-1:0] sbus_adr_o,
  output logic [15:0]         sbus_dat_o,
  output logic                sbus_tga_ps_o,
  output logic                sbus_tga_rs_o,
  input  logic                sbus_ack_i,
  input  logic                sbus_err_i,
  input  logic                sbus_rty_i,
  input  logic                sbus_stall_i,
  input  logic [15:0]         sbus_dat_i,
  // Probe
  output logic [1:0]          prb_sarb_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PS   = 2'b01,
    ST_RS   = 2'b10
  } state_t;

  state_t r_state;
  logic   r_last_rs;   // 1: RS was the most recent owner, so PS wins the next tie
  logic   w_own_ps;
  logic   w_own_rs;

  // Ownership FSM: hold the bus for a whole cycle, hand over directly, round-robin ties
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_state   <= ST_IDLE;
      r_last_rs <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ps_cyc_i && rs_cyc_i) r_state <= r_last_rs ? ST_PS : ST_RS;
          else if (ps_cyc_i)        r_state <= ST_PS;
          else if (rs_cyc_i)        r_state <= ST_RS;
        end
        ST_PS: begin
          if (!ps_cyc_i) begin
            r_last_rs <= 1'b0;
            r_state   <= rs_cyc_i ? ST_RS : ST_IDLE;
          end
        end
        ST_RS: begin
          if (!rs_cyc_i) begin
            r_last_rs <= 1'b1;
            r_state   <= ps_cyc_i ? ST_PS : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_own_ps = (r_state == ST_PS);
  assign w_own_rs = (r_state == ST_RS);

  // Request/response routing from the registered owner; idle bus is all zero
  always_comb begin
    sbus_cyc_o    = 1'b0;
    sbus_stb_o    = 1'b0;
    sbus_we_o     = 1'b0;
    sbus_adr_o    = '0;
    sbus_dat_o    = '0;
    sbus_tga_ps_o = w_own_ps;
    sbus_tga_rs_o = w_own_rs;
    if (w_own_ps) begin
      sbus_cyc_o = ps_cyc_i;
      sbus_stb_o = ps_stb_i;
      sbus_we_o  = ps_we_i;
      sbus_adr_o = ps_adr_i;
      sbus_dat_o = ps_dat_i;
    end else if (w_own_rs) begin
      sbus_cyc_o = rs_cyc_i;
      sbus_stb_o = rs_stb_i;
      sbus_we_o  = rs_we_i;
      sbus_adr_o = rs_adr_i;
      sbus_dat_o = rs_dat_i;
    end
    ps_ack_o   = w_own_ps & sbus_ack_i;
    ps_err_o   = w_own_ps & sbus_err_i;
    ps_rty_o   = w_own_ps & sbus_rty_i;
    ps_stall_o = ~w_own_ps | sbus_stall_i;
    ps_dat_o   = sbus_dat_i;
    rs_ack_o   = w_own_rs & sbus_ack_i;
    rs_err_o   = w_own_rs & sbus_err_i;
    rs_rty_o   = w_own_rs & sbus_rty_i;
    rs_stall_o = ~w_own_rs | sbus_stall_i;
    rs_dat_o   = sbus_dat_i;
  end

  assign prb_sarb_state_o = r_state;

endmodule
